// File: rtl/cd_pkg.sv
// Shared definitions for the rx frame assembler: state encodings, header layout
// constants, status pulse bundle and the destination address filter.
package cd_pkg;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_HDR     = 5'b00010,
        ST_PAYLOAD = 5'b00100,
        ST_CRC     = 5'b01000,
        ST_DROP    = 5'b10000
    } state_t;

    localparam logic [7:0] BCAST_ADDR = 8'hff;

    localparam logic [8:0] IDX_SRC = 9'd0;
    localparam logic [8:0] IDX_DST = 9'd1;
    localparam logic [8:0] IDX_LEN = 9'd2;
    localparam logic [8:0] HDR_LEN = 9'd3;
    localparam logic [8:0] CRC_LEN = 9'd2;

    typedef struct packed {
        logic rx_done;
        logic err_crc;
        logic err_lost;
        logic err_len;
        logic err_short;
        logic err_break;
    } status_t;

    function automatic logic addr_match(input logic [7:0] dst, input logic [7:0] own,
                                        input logic promisc);
        return promisc || (dst == own) || (dst == BCAST_ADDR);
    endfunction

endpackage

// File: rtl/cd_rx_frame_if.sv
// Byte stream from the deserializer plus the byte write port into the rx frame RAM.
interface cd_rx_frame_if #(parameter int A_W = 8);

    logic [7:0]     des_data;
    logic           des_data_clk;
    logic           des_crc_zero;
    logic           des_bus_idle;
    logic           des_break;

    logic           ram_wr_en;
    logic [A_W-1:0] ram_wr_addr;
    logic [7:0]     ram_wr_data;

    modport master (
        input  des_data, des_data_clk, des_crc_zero, des_bus_idle, des_break,
        output ram_wr_en, ram_wr_addr, ram_wr_data
    );

    modport slave (
        output des_data, des_data_clk, des_crc_zero, des_bus_idle, des_break,
        input  ram_wr_en, ram_wr_addr, ram_wr_data
    );

endinterface

// File: rtl/cd_rx_frame.sv
// Frame assembler: parses src, dst, len, payload, crc from the byte stream, stores
// accepted frames in the rx RAM and reports one status pulse per frame.
module cd_rx_frame
    import cd_pkg::*;
#(
    parameter int A_W     = 8,
    parameter int MAX_LEN = 253
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       filter,
    input  logic             promiscuous,
    input  logic             buf_ready,
    input  logic             abort,
    cd_rx_frame_if.master    bus,
    output logic             rx_done,
    output logic [7:0]       rx_len,
    output logic             err_crc,
    output logic             err_lost,
    output logic             err_len,
    output logic             err_short,
    output logic             err_break
);

    localparam logic [8:0] PAYLOAD_END_OFS = HDR_LEN - 9'd1;
    localparam logic [8:0] CRC_END_OFS     = HDR_LEN + CRC_LEN - 9'd1;

    state_t     state_q, state_d;
    logic [8:0] idx_q, idx_d;
    logic [7:0] len_q, len_d;
    logic       nowr_q, nowr_d;
    logic [7:0] rx_len_q, rx_len_d;
    status_t    st_q, st_d;
    logic       wr_en_q, wr_en_d;
    logic [A_W-1:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic [8:0] len9;
    logic       active;

    assign len9   = {1'b0, len_q};
    assign active = state_q inside {ST_HDR, ST_PAYLOAD, ST_CRC};

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        nowr_d   = nowr_q;
        rx_len_d = rx_len_q;
        st_d     = '0;
        wr_en_d  = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = IDX_SRC;
        end else if (bus.des_break) begin
            // A break always swallows a same-cycle byte; it only reports mid-frame.
            if (active) begin
                st_d.err_break = 1'b1;
                state_d        = ST_IDLE;
                idx_d          = IDX_SRC;
            end
        end else if (active && bus.des_bus_idle && !bus.des_data_clk) begin
            st_d.err_short = 1'b1;
            state_d        = ST_IDLE;
            idx_d          = IDX_SRC;
        end else if (state_q == ST_DROP) begin
            if (bus.des_bus_idle) begin
                state_d = ST_IDLE;
                idx_d   = IDX_SRC;
            end
        end else if (bus.des_data_clk) begin
            unique case (state_q)
                ST_IDLE: begin
                    nowr_d  = !buf_ready;
                    wr_en_d = buf_ready;
                    idx_d   = IDX_DST;
                    state_d = ST_HDR;
                end
                ST_HDR: begin
                    if (idx_q == IDX_DST) begin
                        wr_en_d = !nowr_q;
                        if (!addr_match(bus.des_data, filter, promiscuous)) begin
                            state_d = ST_DROP;
                        end else if (nowr_q) begin
                            st_d.err_lost = 1'b1;
                            state_d       = ST_DROP;
                        end else begin
                            idx_d = IDX_LEN;
                        end
                    end else begin
                        wr_en_d = 1'b1;
                        len_d   = bus.des_data;
                        idx_d   = HDR_LEN;
                        if (int'(bus.des_data) > MAX_LEN) begin
                            st_d.err_len = 1'b1;
                            state_d      = ST_DROP;
                        end else if (bus.des_data == 8'd0) begin
                            state_d = ST_CRC;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    wr_en_d = 1'b1;
                    idx_d   = idx_q + 9'd1;
                    if (idx_q == PAYLOAD_END_OFS + len9) state_d = ST_CRC;
                end
                ST_CRC: begin
                    wr_en_d = 1'b1;
                    idx_d   = idx_q + 9'd1;
                    if (idx_q == CRC_END_OFS + len9) begin
                        if (bus.des_crc_zero) begin
                            st_d.rx_done = 1'b1;
                            rx_len_d     = len_q;
                        end else begin
                            st_d.err_crc = 1'b1;
                        end
                        state_d = ST_IDLE;
                        idx_d   = IDX_SRC;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = IDX_SRC;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= IDX_SRC;
            len_q     <= '0;
            nowr_q    <= 1'b0;
            rx_len_q  <= '0;
            st_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            nowr_q    <= nowr_d;
            rx_len_q  <= rx_len_d;
            st_q      <= st_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= idx_q[A_W-1:0];
            wr_data_q <= bus.des_data;
        end
    end

    assign bus.ram_wr_en   = wr_en_q;
    assign bus.ram_wr_addr = wr_addr_q;
    assign bus.ram_wr_data = wr_data_q;

    assign rx_done   = st_q.rx_done;
    assign err_crc   = st_q.err_crc;
    assign err_lost  = st_q.err_lost;
    assign err_len   = st_q.err_len;
    assign err_short = st_q.err_short;
    assign err_break = st_q.err_break;
    assign rx_len    = rx_len_q;

endmodule

// File: tb/tb_cd_rx_frame.sv
// Randomized frame-level bench for cd_rx_frame: a per-frame outcome model queues
// expected RAM writes and status pulses tagged with their cycle; one process compares.
module tb_cd_rx_frame;
    import cd_pkg::*;

    localparam int A_W     = 8;
    localparam int MAX_LEN = 253;

    localparam int K_DONE = 0, K_CRC = 1, K_LOST = 2, K_LEN = 3, K_SHORT = 4, K_BREAK = 5;
    localparam int CUT_NONE = 0, CUT_ABORT = 1, CUT_BREAK = 2, CUT_SHORT = 3, CUT_RESET = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] filter;
    logic       promiscuous, buf_ready, abort;
    logic       rx_done, err_crc, err_lost, err_len, err_short, err_break;
    logic [7:0] rx_len;

    cd_rx_frame_if #(.A_W(A_W)) bus ();

    cd_rx_frame #(.A_W(A_W), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset_n(reset_n), .filter(filter), .promiscuous(promiscuous),
        .buf_ready(buf_ready), .abort(abort), .bus(bus),
        .rx_done(rx_done), .rx_len(rx_len), .err_crc(err_crc), .err_lost(err_lost),
        .err_len(err_len), .err_short(err_short), .err_break(err_break)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int addr; int data; } wr_exp_t;
    typedef struct { int cyc; int kind; int len; } ev_exp_t;

    wr_exp_t    wq[$];
    ev_exp_t    eq[$];
    int         cyc = 0;
    int         n_cmp = 0, n_err = 0;
    int         wr_seen = 0, w0 = 0;
    int         ev_seen[6] = '{default: 0};
    int         ev0[6] = '{default: 0};
    int         model_rx_len = 0;
    int         exp_ev;
    bit         cmp_en = 1'b0;
    logic [5:0] act_ev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            if (bus.ram_wr_en) wr_seen++;
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                check("wr_en", int'(bus.ram_wr_en), 1);
                check("wr_addr", int'(bus.ram_wr_addr), wq[0].addr);
                check("wr_data", int'(bus.ram_wr_data), wq[0].data);
                void'(wq.pop_front());
            end else begin
                check("wr_en_quiet", int'(bus.ram_wr_en), 0);
            end
            act_ev = {err_break, err_short, err_len, err_lost, err_crc, rx_done};
            exp_ev = 0;
            if (eq.size() > 0 && eq[0].cyc == cyc) begin
                exp_ev = 1 << eq[0].kind;
                if (eq[0].kind == K_DONE) model_rx_len = eq[0].len;
                void'(eq.pop_front());
            end
            check("status", int'(act_ev), exp_ev);
            for (int i = 0; i < 6; i++) if (act_ev[i]) ev_seen[i]++;
            check("rx_len", int'(rx_len), model_rx_len);
        end
    end

    task automatic tick(input bit dclk, input logic [7:0] d, input bit crcz, input bit idle,
                        input bit brk, input bit ab, input bit rst);
        bus.des_data_clk = dclk;
        bus.des_data     = dclk ? d : 8'($urandom);
        bus.des_crc_zero = dclk ? crcz : 1'($urandom);
        bus.des_bus_idle = idle;
        bus.des_break    = brk;
        abort            = ab;
        reset_n          = !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        repeat (2) tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic bit accepts(input logic [7:0] dst);
        return promiscuous || dst == filter || dst == 8'hff;
    endfunction

    function automatic int frame_bytes(input bit br, input logic [7:0] dst, input logic [7:0] len);
        return (br && accepts(dst) && int'(len) <= MAX_LEN) ? 5 + int'(len) : 7;
    endfunction

    // Outcome of a frame follows from its fields: which leading bytes get stored, at which
    // byte the frame leaves the active states, and the pulse raised there.
    task automatic send_frame(input bit br, input logic [7:0] src, input logic [7:0] dst,
                              input logic [7:0] len, input logic [7:0] p0, input logic [7:0] p1,
                              input bit good, input int cut, input int cut_at);
        logic [7:0] fb[$];
        bit acc;
        int wr_last, term, pk, k;
        acc = accepts(dst);
        fb  = {src, dst, len};
        for (int i = 3; i < frame_bytes(br, dst, len); i++)
            fb.push_back(i == 3 ? p0 : (i == 4 ? p1 : 8'($urandom)));
        if (!br) begin
            wr_last = -1; term = 1; pk = acc ? K_LOST : -1;
        end else if (!acc) begin
            wr_last = 1; term = 1; pk = -1;
        end else if (int'(len) > MAX_LEN) begin
            wr_last = 2; term = 2; pk = K_LEN;
        end else begin
            wr_last = 4 + int'(len); term = wr_last; pk = good ? K_DONE : K_CRC;
        end
        k = (cut == CUT_NONE) ? fb.size() : cut_at;
        buf_ready = br;
        for (int j = 0; j < k; j++) begin
            if (j <= wr_last) wq.push_back('{cyc + 1, j, int'(fb[j])});
            if (j == term && pk >= 0) eq.push_back('{cyc + 1, pk, int'(len)});
            tick(1'b1, fb[j], (j == term) ? good : 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
            if (j == 0) buf_ready = 1'($urandom);
            repeat ($urandom_range(0, 2)) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        case (cut)
            CUT_ABORT: tick(1'b1, fb[k], 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
            CUT_BREAK: begin
                if (k >= 1 && k <= term) eq.push_back('{cyc + 1, K_BREAK, 0});
                tick(1'b1, fb[k], 1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
            end
            CUT_SHORT: begin
                if (k >= 1 && k <= term) eq.push_back('{cyc + 1, K_SHORT, 0});
                tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            end
            CUT_RESET: begin
                tick(1'b1, fb[k], 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
                model_rx_len = 0;
                tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            default: ;
        endcase
    endtask

    task automatic snap();
        w0  = wr_seen;
        ev0 = ev_seen;
    endtask

    function automatic int ev_delta(input int kind);
        return ev_seen[kind] - ev0[kind];
    endfunction

    function automatic int all_ev_delta();
        int s = 0;
        for (int i = 0; i < 6; i++) s += ev_seen[i] - ev0[i];
        return s;
    endfunction

    initial begin
        filter      = 8'h05;
        promiscuous = 1'b0;
        buf_ready   = 1'b1;
        repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_outputs", int'({rx_done, err_crc, err_lost, err_len, err_short, err_break}), 0);
        check("reset_rx_len", int'(rx_len), 0);
        check("reset_wr_en", int'(bus.ram_wr_en), 0);
        cmp_en = 1'b1;
        idle_gap();

        snap();
        send_frame(1'b1, 8'h01, 8'h05, 8'h02, 8'haa, 8'hbb, 1'b1, CUT_NONE, 0);
        idle_gap();
        check("good_writes", wr_seen - w0, 7);
        check("good_done", ev_delta(K_DONE), 1);
        check("good_rx_len", int'(rx_len), 2);

        snap();
        send_frame(1'b1, 8'h01, 8'h05, 8'h02, 8'hab, 8'hbb, 1'b0, CUT_NONE, 0);
        idle_gap();
        check("bad_crc_writes", wr_seen - w0, 7);
        check("bad_crc_pulse", ev_delta(K_CRC), 1);
        check("bad_crc_no_done", ev_delta(K_DONE), 0);
        check("bad_crc_rx_len", int'(rx_len), 2);

        snap();
        send_frame(1'b1, 8'h01, 8'h07, 8'h02, 8'haa, 8'hbb, 1'b1, CUT_NONE, 0);
        idle_gap();
        check("filtered_writes", wr_seen - w0, 2);
        check("filtered_pulses", all_ev_delta(), 0);
        promiscuous = 1'b1;
        snap();
        send_frame(1'b1, 8'h01, 8'h07, 8'h02, 8'haa, 8'hbb, 1'b1, CUT_NONE, 0);
        idle_gap();
        check("promisc_done", ev_delta(K_DONE), 1);
        promiscuous = 1'b0;

        snap();
        send_frame(1'b0, 8'h01, 8'hff, 8'h02, 8'haa, 8'hbb, 1'b1, CUT_NONE, 0);
        idle_gap();
        check("lost_writes", wr_seen - w0, 0);
        check("lost_pulse", ev_delta(K_LOST), 1);
        snap();
        send_frame(1'b1, 8'h01, 8'h05, 8'hfe, 8'haa, 8'hbb, 1'b1, CUT_NONE, 0);
        idle_gap();
        check("len_pulse", ev_delta(K_LEN), 1);
        check("len_writes", wr_seen - w0, 3);

        snap();
        send_frame(1'b1, 8'h01, 8'h05, 8'h06, 8'h11, 8'h22, 1'b1, CUT_BREAK, 7);
        idle_gap();
        check("break_pulse", ev_delta(K_BREAK), 1);
        check("break_writes", wr_seen - w0, 7);
        snap();
        send_frame(1'b1, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00, 1'b1, CUT_NONE, 0);
        idle_gap();
        check("after_break_done", ev_delta(K_DONE), 1);
        check("after_break_rx_len", int'(rx_len), 0);

        snap();
        send_frame(1'b1, 8'h01, 8'h05, 8'h05, 8'h33, 8'h44, 1'b1, CUT_ABORT, 5);
        idle_gap();
        check("abort_pulses", all_ev_delta(), 0);
        send_frame(1'b1, 8'h01, 8'h05, 8'h01, 8'h55, 8'h00, 1'b1, CUT_NONE, 0);
        idle_gap();
        check("after_abort_rx_len", int'(rx_len), 1);
        snap();
        send_frame(1'b1, 8'h01, 8'h05, 8'h05, 8'h33, 8'h44, 1'b1, CUT_RESET, 5);
        idle_gap();
        check("reset_mid_pulses", all_ev_delta(), 0);
        check("reset_mid_rx_len", int'(rx_len), 0);
        snap();
        send_frame(1'b1, 8'h02, 8'h05, 8'h03, 8'h66, 8'h77, 1'b1, CUT_NONE, 0);
        idle_gap();
        check("after_reset_done", ev_delta(K_DONE), 1);
        check("after_reset_rx_len", int'(rx_len), 3);

        for (int f = 0; f < 250; f++) begin
            logic [7:0] dst, len;
            bit br, good;
            int r, cut, cut_at;
            promiscuous = ($urandom_range(0, 4) == 0);
            r   = $urandom_range(0, 3);
            dst = (r == 0) ? 8'hff : ((r == 1) ? 8'($urandom) : filter);
            len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(254, 255))
                                              : 8'($urandom_range(0, 12));
            br     = ($urandom_range(0, 9) != 0);
            good   = ($urandom_range(0, 9) < 7);
            cut    = ($urandom_range(0, 9) < 7) ? CUT_NONE : int'($urandom_range(1, 4));
            cut_at = $urandom_range(1, frame_bytes(br, dst, len) - 1);
            send_frame(br, 8'($urandom), dst, len, 8'($urandom), 8'($urandom), good, cut, cut_at);
            idle_gap();
        end

        idle_gap();
        check("writes_drained", wq.size(), 0);
        check("pulses_drained", eq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
